// File: rtl/gcfill.sv
// gcfill: multi-channel gain-curve initialiser. Sweeps every bin of each
// channel selected by chan_mask on start and writes the gain RAM with a
// mode pattern (0 unity, 1 fill_value, 2 linear ramp, 3 mute). It writes
// the decimated display RAM in the same cycle.
// Ports: clk, rst (sync, active-high); start/mode/fill_value/chan_mask
// request; abort; busy/done status; gc_chan plus gcurve_* and gcdisp_*
// RAM write ports; gcurve_rdata read-back; verify_err sticky flag.
// Optional GCFILL_VERIFY_EN adds a read-back VERIFY pass after FILL.
module gcfill #(
  parameter int LOGFFTSIZE  = 13,
  parameter int LOGDISPSIZE = 10,
  parameter int LOGNCHAN    = 1,
  parameter int AUDIOWIDTH  = 18,
  parameter int DISPLWIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [1:0]                  mode,
  input  logic [AUDIOWIDTH-1:0]       fill_value,
  input  logic [(1<<LOGNCHAN)-1:0]    chan_mask,
  input  logic                        abort,
  output logic                        busy,
  output logic                        done,
  output logic [LOGNCHAN-1:0]         gc_chan,
  output logic [LOGFFTSIZE-1:0]       gcurve_addr,
  output logic [AUDIOWIDTH-1:0]       gcurve_din,
  output logic                        gcurve_we,
  input  logic [AUDIOWIDTH-1:0]       gcurve_rdata,
  output logic [LOGDISPSIZE-1:0]      gcdisp_addr,
  output logic [DISPLWIDTH-1:0]       gcdisp_din,
  output logic                        gcdisp_we,
  output logic                        verify_err
);

  localparam int NCHAN = 1 << LOGNCHAN;
  localparam int GSH   = AUDIOWIDTH - LOGFFTSIZE;
  localparam int DSH   = LOGFFTSIZE - LOGDISPSIZE;
  localparam int VSH   = AUDIOWIDTH - DISPLWIDTH;

  localparam logic [LOGFFTSIZE-1:0] LAST = '1;
  localparam logic [LOGFFTSIZE-1:0] DMASK =
    LOGFFTSIZE'((1 << DSH) - 1);
  localparam logic [AUDIOWIDTH-1:0] UNITY =
    AUDIOWIDTH'(1) << (AUDIOWIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_VERIFY,
    S_DRAIN
  } state_t;

  state_t state_q, state_n;

  logic [1:0]            mode_q, mode_n;
  logic [AUDIOWIDTH-1:0] fill_q, fill_n;
  logic [NCHAN-1:0]      mask_q, mask_n;

  logic                  busy_n, done_n;
  logic                  we_n, rd_n, clr_err;
  logic [LOGNCHAN-1:0]   chan_n;
  logic [LOGFFTSIZE-1:0] addr_n;
  logic [AUDIOWIDTH-1:0] gain_n;
  logic                  in_fill, last_bin;

  logic [LOGNCHAN:0]     pick_start;
  logic [LOGNCHAN:0]     pick_next;

  function automatic logic [AUDIOWIDTH-1:0] gain_of(
    input logic [1:0]            m,
    input logic [AUDIOWIDTH-1:0] f,
    input logic [LOGFFTSIZE-1:0] i
  );
    logic [AUDIOWIDTH-1:0] g;
    g = '0;
    unique case (1'b1)
      (m == 2'd0): g = UNITY;
      (m == 2'd1): g = f;
      (m == 2'd2): g = AUDIOWIDTH'(i) << GSH;
      default:     g = '0;
    endcase
    return g;
  endfunction

  // Lowest set mask bit, optionally restricted to channels above c.
  // Result MSB flags that a channel was found.
  function automatic logic [LOGNCHAN:0] pick(
    input logic [NCHAN-1:0]    m,
    input logic [LOGNCHAN-1:0] c,
    input logic                after
  );
    logic [LOGNCHAN:0] r;
    r = '0;
    for (int j = NCHAN - 1; j >= 0; j--) begin
      if (m[j] && (!after || j > int'(c)))
        r = {1'b1, LOGNCHAN'(j)};
    end
    return r;
  endfunction

  assign pick_start = pick(chan_mask, '0, 1'b0);
  assign pick_next  = pick(mask_q, gc_chan, 1'b1);
  assign last_bin   = (gcurve_addr == LAST);
  assign in_fill    = (state_q == S_FILL);

`ifdef GCFILL_VERIFY_EN
  logic [LOGNCHAN:0] pick_first;
  assign pick_first = pick(mask_q, '0, 1'b0);
`endif

  always_comb begin
    state_n = state_q;
    mode_n  = mode_q;
    fill_n  = fill_q;
    mask_n  = mask_q;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    we_n    = 1'b0;
    rd_n    = 1'b0;
    clr_err = 1'b0;
    chan_n  = '0;
    addr_n  = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_n  = mode;
          fill_n  = fill_value;
          mask_n  = chan_mask;
          clr_err = 1'b1;
          if (pick_start[LOGNCHAN]) begin
            state_n = S_FILL;
            busy_n  = 1'b1;
            we_n    = 1'b1;
            chan_n  = pick_start[LOGNCHAN-1:0];
          end else begin
            done_n  = 1'b1;
          end
        end
      end
      S_FILL, S_VERIFY: begin
        if (abort) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else if (!last_bin) begin
          busy_n = 1'b1;
          we_n   = in_fill;
          rd_n   = !in_fill;
          chan_n = gc_chan;
          addr_n = gcurve_addr + 1'b1;
        end else if (pick_next[LOGNCHAN]) begin
          busy_n = 1'b1;
          we_n   = in_fill;
          rd_n   = !in_fill;
          chan_n = pick_next[LOGNCHAN-1:0];
        end else if (in_fill) begin
`ifdef GCFILL_VERIFY_EN
          state_n = S_VERIFY;
          busy_n  = 1'b1;
          rd_n    = 1'b1;
          chan_n  = pick_first[LOGNCHAN-1:0];
`else
          state_n = S_IDLE;
          done_n  = 1'b1;
`endif
        end else begin
          // one extra cycle so the last read-back can be compared
          state_n = S_DRAIN;
          busy_n  = 1'b1;
        end
      end
      S_DRAIN: begin
        state_n = S_IDLE;
        done_n  = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign gain_n = gain_of(mode_n, fill_n, addr_n);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      fill_q      <= '0;
      mask_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      gc_chan     <= '0;
      gcurve_addr <= '0;
      gcurve_din  <= '0;
      gcurve_we   <= 1'b0;
      gcdisp_addr <= '0;
      gcdisp_din  <= '0;
      gcdisp_we   <= 1'b0;
    end else begin
      state_q     <= state_n;
      mode_q      <= mode_n;
      fill_q      <= fill_n;
      mask_q      <= mask_n;
      busy        <= busy_n;
      done        <= done_n;
      gc_chan     <= chan_n;
      gcurve_addr <= addr_n;
      gcurve_we   <= we_n;
      gcurve_din  <= we_n ? gain_n : '0;
      gcdisp_we   <= we_n && ((addr_n & DMASK) == '0);
      gcdisp_addr <= we_n ?
        LOGDISPSIZE'(addr_n >> DSH) : '0;
      gcdisp_din  <= we_n ?
        DISPLWIDTH'(gain_n >> VSH) : '0;
    end
  end

`ifdef GCFILL_VERIFY_EN
  logic                  rd_q, cmp_q;
  logic [AUDIOWIDTH-1:0] exp_q;

  // rd_q marks a read address on the bus this cycle; the RAM answers
  // one cycle later, so expected data rides along one stage behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q       <= 1'b0;
      cmp_q      <= 1'b0;
      exp_q      <= '0;
      verify_err <= 1'b0;
    end else begin
      rd_q  <= rd_n;
      cmp_q <= rd_q && !abort;
      exp_q <= gain_of(mode_q, fill_q, gcurve_addr);
      if (clr_err)
        verify_err <= 1'b0;
      else if (cmp_q && (gcurve_rdata != exp_q))
        verify_err <= 1'b1;
    end
  end
`else
  logic unused_rd;
  assign unused_rd  = ^{gcurve_rdata, rd_n};
  assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_gcfill.sv
// tb_gcfill: randomized and directed bench for gcfill with a
// queue-based sweep model and a RAM model that can corrupt bin 7.
module tb_gcfill;

  localparam int LF = 4;
  localparam int LD = 2;
  localparam int LN = 1;
  localparam int AW = 8;
  localparam int DW = 4;
  localparam int NB = 1 << LF;
  localparam int DD = 1 << (LF - LD);

`ifdef GCFILL_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = '0;
  logic [AW-1:0] fill_value = '0;
  logic [1:0]    chan_mask = '0;
  logic          abort = 1'b0;
  logic          busy, done, gcurve_we, gcdisp_we, verify_err;
  logic [LN-1:0] gc_chan;
  logic [LF-1:0] gcurve_addr;
  logic [AW-1:0] gcurve_din;
  logic [AW-1:0] gcurve_rdata = '0;
  logic [LD-1:0] gcdisp_addr;
  logic [DW-1:0] gcdisp_din;

  gcfill #(
    .LOGFFTSIZE(LF), .LOGDISPSIZE(LD), .LOGNCHAN(LN),
    .AUDIOWIDTH(AW), .DISPLWIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .fill_value(fill_value), .chan_mask(chan_mask),
    .abort(abort), .busy(busy), .done(done),
    .gc_chan(gc_chan), .gcurve_addr(gcurve_addr),
    .gcurve_din(gcurve_din), .gcurve_we(gcurve_we),
    .gcurve_rdata(gcurve_rdata), .gcdisp_addr(gcdisp_addr),
    .gcdisp_din(gcdisp_din), .gcdisp_we(gcdisp_we),
    .verify_err(verify_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // RAM model: registered read, bin 7 optionally corrupted on read.
  logic [AW-1:0] ram [2][NB];
  bit corrupt = 1'b0;

  always @(posedge clk) begin
    if (gcurve_we)
      ram[gc_chan][gcurve_addr] <= gcurve_din;
    gcurve_rdata <= ram[gc_chan][gcurve_addr] ^
      ((corrupt && gcurve_addr == 7) ? AW'(1) : AW'(0));
  end

  // Behavioural model: on an accepted start, the whole sweep is
  // expanded into a list of per-cycle steps (write, read, tail).
  typedef struct {
    int kind;
    int ch;
    int idx;
    int g;
  } step_t;

  step_t q[$];
  bit    active = 1'b0;
  bit    e_zero = 1'b1;
  bit    e_busy, e_done, e_we, e_rd, e_errchk, e_err, err_pred;
  int    e_ch, e_idx, e_g;

  function automatic int gain_m(input int md, input int fl,
                                input int i);
    if (md == 0) return 1 << (AW - 1);
    if (md == 1) return fl;
    if (md == 2) return i * (1 << (AW - LF));
    return 0;
  endfunction

  task automatic present(input step_t s);
    active = 1'b1;
    e_busy = 1'b1;
    e_we   = (s.kind == 0);
    e_rd   = (s.kind == 1);
    e_ch   = s.ch;
    e_idx  = s.idx;
    e_g    = s.g;
    e_errchk = (s.kind == 0);
    e_err    = 1'b0;
  endtask

  always @(posedge clk) begin
    e_done = 0; e_busy = 0; e_we = 0; e_rd = 0; e_errchk = 0;
    if (rst) begin
      active = 0;
      q.delete();
      e_zero = 1;
      e_err  = 0;
    end else begin
      e_zero = 0;
      if (!active) begin
        if (start) begin
          int k;
          k = 0;
          q.delete();
          for (int c = 0; c < 2; c++)
            if (chan_mask[c]) begin
              k++;
              for (int i = 0; i < NB; i++)
                q.push_back('{0, c, i,
                  gain_m(int'(mode), int'(fill_value), i)});
            end
          if (VER && k > 0) begin
            for (int c = 0; c < 2; c++)
              if (chan_mask[c])
                for (int i = 0; i < NB; i++)
                  q.push_back('{1, c, i, 0});
            q.push_back('{2, 0, 0, 0});
          end
          err_pred = VER && corrupt && (k > 0);
          if (q.size() == 0) begin
            e_done = 1; e_errchk = 1; e_err = 0;
          end else begin
            present(q.pop_front());
          end
        end
      end else if (abort) begin
        q.delete();
        active = 0;
        e_done = 1;
      end else if (q.size() > 0) begin
        present(q.pop_front());
      end else begin
        active = 0;
        e_done = 1;
        e_errchk = 1;
        e_err = err_pred;
      end
    end
  end

  always @(negedge clk) begin
    if (e_zero) begin
      chk("reset_outputs",
          32'({busy, done, gc_chan, gcurve_addr, gcurve_din,
               gcurve_we, gcdisp_addr, gcdisp_din, gcdisp_we,
               verify_err}), 32'd0);
    end else begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("we", 32'(gcurve_we), 32'(e_we));
      chk("dwe", 32'(gcdisp_we),
          32'(e_we && (e_idx % DD == 0)));
      if (e_we || e_rd) begin
        chk("chan", 32'(gc_chan), e_ch);
        chk("addr", 32'(gcurve_addr), e_idx);
      end
      if (e_we) begin
        chk("din", 32'(gcurve_din), e_g);
        if (e_idx % DD == 0) begin
          chk("daddr", 32'(gcdisp_addr), e_idx / DD);
          chk("ddin", 32'(gcdisp_din), e_g >> (AW - DW));
        end
      end
      if (e_errchk)
        chk("verify_err", 32'(verify_err), 32'(e_err));
      if (!VER)
        chk("verify_err_tied", 32'(verify_err), 0);
    end
  end

  // Per-sweep observations for literal checks.
  int lat, wr, wr_pre, fw_ch, fw_addr;
  bit err_done;
  int dq[$];

  task automatic go(input int md, input int fl, input int mk,
                    input int ab = 0, input int sp = 0,
                    input int rs = 0, input bit sa = 0);
    int cyc;
    bit first;
    wr = 0; wr_pre = 0; fw_ch = -1; fw_addr = -1;
    err_done = 0; first = 1; dq.delete();
    mode = 2'(md); fill_value = AW'(fl); chan_mask = 2'(mk);
    start = 1; abort = sa;
    @(negedge clk);
    start = 0; abort = 0;
    cyc = 1;
    forever begin
      if (rs != 0 && cyc == rs + 1) begin
        chk("rst_all_zero",
            32'({busy, done, gcurve_we, gcdisp_we,
                 gc_chan, gcurve_addr, gcurve_din}), 0);
        break;
      end
      if (gcurve_we) begin
        wr++;
        if (ab == 0 || cyc < ab) wr_pre++;
        if (first) begin
          fw_ch = int'(gc_chan);
          fw_addr = int'(gcurve_addr);
          first = 0;
        end
      end
      if (gcdisp_we) dq.push_back(int'(gcdisp_din));
      if (done) begin
        err_done = verify_err;
        break;
      end
      if (cyc > 300) begin
        n_cmp++; n_fail++;
        $display("FAIL timeout: no done after %0d cycles", cyc);
        break;
      end
      abort = (cyc == ab);
      start = (cyc == sp);
      rst   = (rs != 0 && cyc == rs);
      @(negedge clk);
      cyc++;
    end
    lat = cyc;
    abort = 0; start = 0; rst = 0;
    @(negedge clk);
  endtask

  function automatic int lat_of(input int k);
    return VER ? 2 * k * NB + 2 : k * NB + 1;
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);

    go(0, 0, 3);
    chk("t1_latency", lat, lat_of(2));
    chk("t1_writes", wr, 32);
    chk("t1_disp_writes", dq.size(), 8);
    foreach (dq[k]) chk("t1_disp_din", dq[k], 8);

    go(2, 0, 2);
    chk("t2_latency", lat, lat_of(1));
    chk("t2_first_chan", fw_ch, 1);
    chk("t2_disp_writes", dq.size(), 4);
    for (int k = 0; k < 4 && k < dq.size(); k++)
      chk("t2_disp_din", dq[k], 4 * k);

    go(1, 8'h5A, 3, 6);
    chk("t3_latency", lat, 7);
    chk("t3_writes_before_abort", wr_pre, 5);

    go(0, 0, 0);
    chk("t4_empty_latency", lat, 1);
    chk("t4_empty_writes", wr, 0);

    go(1, 8'h33, 1, 0, 5);
    chk("t4_spur_latency", lat, lat_of(1));
    chk("t4_spur_writes", wr, 16);

    go(3, 0, 3, 0, 0, 9);
    go(0, 0, 1);
    chk("t5_restart_chan", fw_ch, 0);
    chk("t5_restart_addr", fw_addr, 0);

    go(1, 8'hC3, 2, 0, 0, 0, 1);
    chk("start_beats_abort", wr, 16);

    corrupt = 1;
    go(0, 0, 1);
    chk("t6_corrupt_err", 32'(err_done), 32'(VER));
    chk("t6_corrupt_latency", lat, VER ? 34 : 17);
    corrupt = 0;
    go(0, 0, 1);
    chk("t6_clean_err", 32'(err_done), 0);
    chk("t6_clean_latency", lat, VER ? 34 : 17);

    for (int n = 0; n < 40; n++) begin
      int ab, sp;
      corrupt = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 2) == 0) ?
           int'($urandom_range(1, 40)) : 0;
      sp = ($urandom_range(0, 3) == 0) ?
           int'($urandom_range(1, 40)) : 0;
      go(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
         int'($urandom_range(0, 3)), ab, sp);
    end
    corrupt = 0;

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
